alarm_trigger: RTL and testbench
================================

# alarm_trigger

Consumer side of the alarm-set path. Keeps a free-running BCD MM:SS clock and latches the 4-digit BCD alarm value when the setter raises its finish level. Raises `ringing` when the clock reaches the latched alarm, and handles dismiss, snooze and auto-stop. Sits between the alarm-set block and the 7-segment/LED output stage.

## Interface
Parameters:
- `TICK_DIV`, default 100000000: clk cycles per one-second tick; must be ≥2.
- `RING_SECS`, default 30: ticks of ringing before auto-stop.
- `SNOOZE_SECS`, default 60: ticks spent in snooze before ringing again.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `alarm_in` in 16: target alarm as BCD digits [15:12][11:8][7:4][3:0] = M10 M1 S10 S1.
- `arm` in 1: level from the setter's finish flag. Rising edge latches `alarm_in`; falling edge disarms.
- `dismiss` in 1: one-cycle pulse, already debounced.
- `snooze` in 1: one-cycle pulse, already debounced.
- `now` out 16: running time, BCD MM:SS, same digit order as `alarm_in`.
- `sec_tick` out 1: one-cycle pulse per second.
- `ringing` out 1: high while in RINGING.
- `blink` out 1: toggles on each `sec_tick` while ringing; 0 otherwise.
- `armed` out 1: high in ARMED or SNOOZE.
- `err` out 1: one-cycle pulse when an invalid alarm is rejected.

## Operation
Time base:
- Divider counts 0..TICK_DIV-1 and wraps.
- `sec_tick` is registered high for the cycle after the divider equals TICK_DIV-1.
- `now` increments in the same cycle `sec_tick` is high.
- BCD increment: S1 9→0 carries to S10; S10 5→0 carries to M1; M1 9→0 carries to M10; 59:59 wraps to 00:00.
- `now` runs in every state.

Edge detection:
- `arm_q` is the registered copy of `arm`.
- Rise = `arm & ~arm_q`; fall = `~arm & arm_q`.

Alarm validation:
- Valid means every digit ≤9, M10 ≤5 and S10 ≤5.
- Invalid on rise: stay IDLE, pulse `err`, leave `target` unchanged.

FSM (IDLE, ARMED, RINGING, SNOOZE):
- **IDLE:** valid rise → latch `target`, clear `snooze_cnt`, go to ARMED.
- **ARMED:** when `now == target`, go to RINGING and clear `ring_cnt`.
- **RINGING:**
  - `dismiss` → IDLE.
  - else `snooze` with `snooze_cnt < MAX_SNOOZE` → SNOOZE: load `wait_cnt = SNOOZE_SECS`, increment `snooze_cnt`.
  - else `sec_tick` with `ring_cnt == RING_SECS-1` → IDLE (auto-stop).
  - else `sec_tick` → increment `ring_cnt`.
- **SNOOZE:**
  - `dismiss` → IDLE.
  - `sec_tick` → decrement `wait_cnt`; at 1→0, go to RINGING and clear `ring_cnt`.
- **Any state except IDLE:** a fall on `arm` → IDLE. A fall takes priority over every other event.

Priority within a cycle: arm fall > dismiss > snooze > tick-driven transitions.

Other rules:
- A `snooze` pulse when `snooze_cnt == MAX_SNOOZE` is ignored; ringing continues.
- `snooze`/`dismiss` pulses in IDLE or ARMED are ignored.
- A rise on `arm` outside IDLE is ignored. `arm` must fall and rise again to load a new alarm.
- After auto-stop or dismiss the block stays IDLE while `arm` is still high. No re-trigger at the next wrap.
- `blink` clears to 0 on every entry to RINGING and on leaving it.

## Timing
- Reset values: `now` = 0x0000, divider 0, `sec_tick` 0, `ringing` 0, `blink` 0, `armed` 0, `err` 0, state IDLE, `target` 0, `arm_q` 0. Counters are cleared.
- Reset mid-ring drops `ringing` the cycle after `resetn` is sampled low.
- `arm` rise at edge N: `armed` is high at N+1.
- Match: `ringing` is high one cycle after `now` first equals `target`.
- If `target` equals `now` at arm time, `ringing` is high at N+2.
- `dismiss`/`snooze` sampled at edge N: `ringing` is low at N+1.
- Snooze to re-ring: exactly SNOOZE_SECS `sec_tick` pulses after the snooze press.
- Auto-stop: `ringing` falls the cycle after the RING_SECS-th tick inside RINGING.
- `err` lasts exactly 1 cycle.

## Test plan
Simulation settings: TICK_DIV=4, RING_SECS=3, SNOOZE_SECS=2, MAX_SNOOZE=1.

- **Reset and count:** release reset, run 4×3600 cycles → `now` steps 00:00, 00:01 … 59:59, then 00:00. One `sec_tick` every 4 cycles. Spot-check 00:09→00:10, 00:59→01:00, 09:59→10:00.
- **Arm and ring:** `alarm_in`=0x0005, pulse `arm` high at `now`=00:00 → `armed`=1. `ringing` rises one cycle after `now`=00:05. `blink` toggles on each tick. Auto-stop after 3 ticks → IDLE, `armed`=0.
- **Snooze:** ring, then `snooze` → `ringing` 0 for 2 ticks, then 1 again. A second `snooze` is ignored (`ringing` stays 1). `dismiss` → IDLE.
- **Invalid alarm:** `alarm_in`=0x0070 with an `arm` rise → `err` pulses for 1 cycle, state stays IDLE, `armed`=0.
- **Simultaneous events:** `dismiss` and `snooze` in the same cycle while ringing → IDLE. An `arm` fall together with `snooze` → IDLE.
- **Reset mid-operation:** assert `resetn`=0 while in SNOOZE → all outputs at reset values next cycle, `now`=0x0000.

Source files
------------

// File: rtl/alarm_trigger.sv
// rtl/alarm_trigger.sv - BCD MM:SS time base with alarm latch, ring, snooze and auto-stop control
module alarm_trigger #(
    parameter int TICK_DIV    = 100000000,
    parameter int RING_SECS   = 30,
    parameter int SNOOZE_SECS = 60,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] alarm_in,
    input  logic        arm,
    input  logic        dismiss,
    input  logic        snooze,
    output logic [15:0] now,
    output logic        sec_tick,
    output logic        ringing,
    output logic        blink,
    output logic        armed,
    output logic        err
);
    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(RING_SECS + 1);
    localparam int WW = $clog2(SNOOZE_SECS + 1);
    localparam int NW = $clog2(MAX_SNOOZE + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RINGING, S_SNOOZE} state_t;

    state_t          r_state, w_state_n;
    logic [DW-1:0]   r_div;
    logic            r_sec_tick;
    logic [15:0]     r_now;
    logic            r_arm_q;
    logic [15:0]     r_target, w_target_n;
    logic [RW-1:0]   r_ring_cnt, w_ring_cnt_n;
    logic [WW-1:0]   r_wait_cnt, w_wait_cnt_n;
    logic [NW-1:0]   r_snooze_cnt, w_snooze_cnt_n;
    logic            r_blink, w_blink_n;
    logic            r_err, w_err_n;

    logic            w_wrap;
    logic            w_rise;
    logic            w_fall;
    logic            w_valid;

    // Each digit rolls over at its own limit and carries into the next one.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    r[11:8] = t[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    r[15:12] = (t[15:12] == 4'd5) ? 4'd0 : t[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign w_wrap  = (r_div == DW'(TICK_DIV - 1));
    assign w_rise  = arm & ~r_arm_q;
    assign w_fall  = ~arm & r_arm_q;
    assign w_valid = (alarm_in[15:12] <= 4'd5) && (alarm_in[11:8] <= 4'd9) &&
                     (alarm_in[7:4] <= 4'd5) && (alarm_in[3:0] <= 4'd9);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_div      <= '0;
            r_sec_tick <= 1'b0;
            r_now      <= 16'h0000;
            r_arm_q    <= 1'b0;
        end else begin
            r_div      <= w_wrap ? '0 : r_div + DW'(1);
            r_sec_tick <= w_wrap;
            r_now      <= w_wrap ? bcd_inc(r_now) : r_now;
            r_arm_q    <= arm;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_target     <= 16'h0000;
            r_ring_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_snooze_cnt <= '0;
            r_blink      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_target     <= w_target_n;
            r_ring_cnt   <= w_ring_cnt_n;
            r_wait_cnt   <= w_wait_cnt_n;
            r_snooze_cnt <= w_snooze_cnt_n;
            r_blink      <= w_blink_n;
            r_err        <= w_err_n;
        end
    end

    // Arm fall outranks dismiss, which outranks snooze, which outranks ticks.
    always_comb begin
        w_state_n      = r_state;
        w_target_n     = r_target;
        w_ring_cnt_n   = r_ring_cnt;
        w_wait_cnt_n   = r_wait_cnt;
        w_snooze_cnt_n = r_snooze_cnt;
        w_err_n        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    if (w_valid) begin
                        w_target_n     = alarm_in;
                        w_snooze_cnt_n = '0;
                        w_state_n      = S_ARMED;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (w_fall) begin
                    w_state_n = S_IDLE;
                end else if (r_now == r_target) begin
                    w_state_n    = S_RINGING;
                    w_ring_cnt_n = '0;
                end
            end
            S_RINGING: begin
                if (w_fall || dismiss) begin
                    w_state_n = S_IDLE;
                end else if (snooze && (r_snooze_cnt < NW'(MAX_SNOOZE))) begin
                    w_state_n      = S_SNOOZE;
                    w_wait_cnt_n   = WW'(SNOOZE_SECS);
                    w_snooze_cnt_n = r_snooze_cnt + NW'(1);
                end else if (r_sec_tick) begin
                    if (r_ring_cnt == RW'(RING_SECS - 1)) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_ring_cnt_n = r_ring_cnt + RW'(1);
                    end
                end
            end
            S_SNOOZE: begin
                if (w_fall || dismiss) begin
                    w_state_n = S_IDLE;
                end else if (r_sec_tick) begin
                    w_wait_cnt_n = r_wait_cnt - WW'(1);
                    if (r_wait_cnt == WW'(1)) begin
                        w_state_n    = S_RINGING;
                        w_ring_cnt_n = '0;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Blink only survives while staying in RINGING, so entry and exit both clear it.
    always_comb begin
        w_blink_n = 1'b0;
        if ((r_state == S_RINGING) && (w_state_n == S_RINGING)) begin
            w_blink_n = r_blink ^ r_sec_tick;
        end
    end

    assign now      = r_now;
    assign sec_tick = r_sec_tick;
    assign ringing  = (r_state == S_RINGING);
    assign blink    = r_blink;
    assign armed    = (r_state == S_ARMED) || (r_state == S_SNOOZE);
    assign err      = r_err;
endmodule

// File: tb/tb_alarm_trigger.sv
// tb/tb_alarm_trigger.sv - directed self-checking bench for alarm_trigger
module tb_alarm_trigger;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] alarm_in = 16'h0000;
    logic        arm = 1'b0;
    logic        dismiss = 1'b0;
    logic        snooze = 1'b0;
    logic [15:0] now;
    logic        sec_tick;
    logic        ringing;
    logic        blink;
    logic        armed;
    logic        err;

    int checks = 0;
    int errors = 0;
    int k = 0;

    alarm_trigger #(
        .TICK_DIV(4), .RING_SECS(3), .SNOOZE_SECS(2), .MAX_SNOOZE(1)
    ) dut (
        .clk(clk), .resetn(resetn), .alarm_in(alarm_in), .arm(arm),
        .dismiss(dismiss), .snooze(snooze), .now(now), .sec_tick(sec_tick),
        .ringing(ringing), .blink(blink), .armed(armed), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout k=%0d", k);
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] bcd_of(input int s);
        int m;
        int ss;
        m  = (s % 3600) / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        arm     = 1'b0;
        snooze  = 1'b0;
        dismiss = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        k = 0;
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst_now", now, 16'h0000);
        chk("rst_tick", {15'd0, sec_tick}, 16'd0);
        chk("rst_ringing", {15'd0, ringing}, 16'd0);
        chk("rst_blink", {15'd0, blink}, 16'd0);
        chk("rst_armed", {15'd0, armed}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);

        // Full hour of counting, including every digit carry and the wrap
        for (int i = 1; i <= 14400; i++) begin
            step();
            chk("count_now", now, bcd_of(k / 4));
            chk("count_tick", {15'd0, sec_tick}, {15'd0, (k % 4) == 0});
            if (k == 40)    chk("spot_0010", now, 16'h0010);
            if (k == 240)   chk("spot_0100", now, 16'h0100);
            if (k == 2400)  chk("spot_1000", now, 16'h1000);
        end
        chk("wrap_0000", now, 16'h0000);

        // Arm, ring, blink, auto-stop
        do_reset();
        alarm_in = 16'h0005;
        arm = 1'b1;
        step();
        chk("arm_armed", {15'd0, armed}, 16'd1);
        run_to(20);
        chk("arm_now5", now, 16'h0005);
        chk("arm_notyet", {15'd0, ringing}, 16'd0);
        step();
        chk("ring_on", {15'd0, ringing}, 16'd1);
        chk("ring_blink0", {15'd0, blink}, 16'd0);
        run_to(25);
        chk("ring_blink1", {15'd0, blink}, 16'd1);
        run_to(29);
        chk("ring_blink2", {15'd0, blink}, 16'd0);
        run_to(32);
        chk("ring_before_stop", {15'd0, ringing}, 16'd1);
        step();
        chk("autostop_ring", {15'd0, ringing}, 16'd0);
        chk("autostop_armed", {15'd0, armed}, 16'd0);
        run_to(60);
        chk("no_retrigger", {15'd0, ringing}, 16'd0);

        // Snooze, re-ring, ignored second snooze, dismiss
        do_reset();
        alarm_in = 16'h0002;
        arm = 1'b1;
        run_to(9);
        chk("sn_ring", {15'd0, ringing}, 16'd1);
        run_to(10);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("sn_ring_off", {15'd0, ringing}, 16'd0);
        chk("sn_armed", {15'd0, armed}, 16'd1);
        run_to(16);
        chk("sn_still_off", {15'd0, ringing}, 16'd0);
        step();
        chk("sn_rering", {15'd0, ringing}, 16'd1);
        chk("sn_rering_blink", {15'd0, blink}, 16'd0);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("sn_second_ignored", {15'd0, ringing}, 16'd1);
        dismiss = 1'b1;
        step();
        dismiss = 1'b0;
        chk("sn_dismiss_ring", {15'd0, ringing}, 16'd0);
        chk("sn_dismiss_armed", {15'd0, armed}, 16'd0);

        // Invalid alarm rejected
        do_reset();
        alarm_in = 16'h0070;
        arm = 1'b1;
        step();
        chk("inv_err", {15'd0, err}, 16'd1);
        chk("inv_armed", {15'd0, armed}, 16'd0);
        step();
        chk("inv_err_1cyc", {15'd0, err}, 16'd0);
        chk("inv_armed2", {15'd0, armed}, 16'd0);

        // Simultaneous dismiss+snooze, then arm fall with snooze
        do_reset();
        alarm_in = 16'h0001;
        arm = 1'b1;
        run_to(5);
        chk("sim_ring", {15'd0, ringing}, 16'd1);
        dismiss = 1'b1;
        snooze = 1'b1;
        step();
        dismiss = 1'b0;
        snooze = 1'b0;
        chk("sim_ds_ring", {15'd0, ringing}, 16'd0);
        chk("sim_ds_armed", {15'd0, armed}, 16'd0);
        arm = 1'b0;
        step();
        alarm_in = 16'h0003;
        arm = 1'b1;
        step();
        chk("sim_rearm", {15'd0, armed}, 16'd1);
        run_to(13);
        chk("sim_ring2", {15'd0, ringing}, 16'd1);
        arm = 1'b0;
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("sim_fall_ring", {15'd0, ringing}, 16'd0);
        chk("sim_fall_armed", {15'd0, armed}, 16'd0);

        // Reset while snoozing
        do_reset();
        alarm_in = 16'h0001;
        arm = 1'b1;
        run_to(5);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("rs_in_snooze", {15'd0, armed}, 16'd1);
        step();
        resetn = 1'b0;
        arm = 1'b0;
        step();
        chk("rs_now", now, 16'h0000);
        chk("rs_tick", {15'd0, sec_tick}, 16'd0);
        chk("rs_armed", {15'd0, armed}, 16'd0);
        chk("rs_ringing", {15'd0, ringing}, 16'd0);
        chk("rs_blink", {15'd0, blink}, 16'd0);
        chk("rs_err", {15'd0, err}, 16'd0);
        resetn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
